// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache onto one memory port: one transaction at a
// time, round-robin on simultaneous requests, memory-side outputs driven from flops.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   proc_reset,

    input  logic                   i_read,
    input  logic                   i_write,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [BLOCK_WIDTH-1:0] i_wdata,
    output logic [BLOCK_WIDTH-1:0] i_rdata,
    output logic                   i_ready,

    input  logic                   d_read,
    input  logic                   d_write,
    input  logic [ADDR_WIDTH-1:0]  d_addr,
    input  logic [BLOCK_WIDTH-1:0] d_wdata,
    output logic [BLOCK_WIDTH-1:0] d_rdata,
    output logic                   d_ready,

    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [BLOCK_WIDTH-1:0] mem_wdata,
    input  logic [BLOCK_WIDTH-1:0] mem_rdata,
    input  logic                   mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;   // 0 = I-cache, 1 = D-cache
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [BLOCK_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic i_active;
    logic d_active;
    logic grant_sel;

    assign i_active = i_read | i_write;
    assign d_active = d_read | d_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        grant_sel    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_active || d_active) begin
                    // On a tie the requester that did not win last time goes first.
                    grant_sel    = (i_active && d_active) ? ~last_grant_q : d_active;
                    last_grant_d = grant_sel;
                    state_d      = grant_sel ? SERVE_D : SERVE_I;
                    mem_write_d  = grant_sel ? d_write : i_write;
                    mem_read_d   = grant_sel ? ~d_write : ~i_write;
                    mem_addr_d   = grant_sel ? d_addr  : i_addr;
                    mem_wdata_d  = grant_sel ? d_wdata : i_wdata;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion is steered combinationally so the cache sees it in the same cycle.
    assign i_ready = (state_q == SERVE_I) && mem_ready;
    assign d_ready = (state_q == SERVE_D) && mem_ready;
    assign i_rdata = i_ready ? mem_rdata : '0;
    assign d_rdata = d_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a bus-ownership model and end to end against a memory image.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int BW = 128;
    localparam int WAIT_LIMIT = 200;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [BW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // op: 0 = read, 1 = write, 2 = read and write both high (treated as write)
    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } req_t;

    req_t todo_i[$];
    req_t todo_d[$];
    req_t cur[2];
    bit   pend[2];
    int   wait_cnt[2];
    int   rdy_cnt[2];
    int   log_q[$];      // completions: who*2 + is_write

    bit auto_en   = 0;
    int lat_cfg   = 0;   // negative: random latency
    int stray_pct = 0;
    int drop_pct  = 0;

    logic [BW-1:0] mem_arr [logic [AW-1:0]];
    logic [BW-1:0] ref_arr [logic [AW-1:0]];
    bit mbusy = 0;
    int mcnt  = 0;

    // Bus-ownership model: who currently owns the memory port, and who won last.
    bit            m_live = 0;
    bit            m_who  = 0;
    bit            m_last = 0;
    bit            m_w    = 0;
    logic [AW-1:0] m_addr = '0;
    logic [BW-1:0] m_wdata = '0;

    function automatic logic [BW-1:0] dflt(input logic [AW-1:0] a);
        return {4{4'h0, a}};
    endfunction

    function automatic logic [BW-1:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic req_t mk_req(input logic [1:0] op, input logic [AW-1:0] a, input logic [BW-1:0] w);
        req_t r;
        r.op = op; r.addr = a; r.wdata = w;
        return r;
    endfunction

    task automatic step(input bit rst);
        bit            rdy, is_w, ia, da, who;
        logic [BW-1:0] rd, exp_rd;
        logic [AW-1:0] a;
        string         tg;

        @(negedge clk);
        proc_reset = rst;

        for (int x = 0; x < 2; x++) begin
            if (rst) begin
                pend[x] = 0;
            end else if (!pend[x]) begin
                if (x == 0 && todo_i.size() > 0) begin
                    cur[0] = todo_i.pop_front(); pend[0] = 1; wait_cnt[0] = 0;
                end else if (x == 1 && todo_d.size() > 0) begin
                    cur[1] = todo_d.pop_front(); pend[1] = 1; wait_cnt[1] = 0;
                end else if (auto_en && $urandom_range(99) < 30) begin
                    cur[x] = mk_req(2'($urandom_range(2)), AW'(28'h0A00000 + $urandom_range(7)), rand_blk());
                    pend[x] = 1; wait_cnt[x] = 0;
                end
            end else if (auto_en && !(m_live && m_who == x[0]) && $urandom_range(99) < drop_pct) begin
                pend[x] = 0;
            end
        end
        i_read  = pend[0] && cur[0].op != 2'd1;
        i_write = pend[0] && cur[0].op != 2'd0;
        i_addr  = pend[0] ? cur[0].addr : '0;
        i_wdata = pend[0] ? cur[0].wdata : '0;
        d_read  = pend[1] && cur[1].op != 2'd1;
        d_write = pend[1] && cur[1].op != 2'd0;
        d_addr  = pend[1] ? cur[1].addr : '0;
        d_wdata = pend[1] ? cur[1].wdata : '0;

        mem_ready = 1'b0;
        mem_rdata = '0;
        if (!rst && (mem_read || mem_write)) begin
            if (!mbusy) begin
                mbusy = 1;
                mcnt  = (lat_cfg < 0) ? int'($urandom_range(4)) : lat_cfg;
            end
            if (mcnt == 0) begin
                mem_ready = 1'b1;
                mbusy     = 0;
                if (mem_write) mem_arr[mem_addr] = mem_wdata;
                else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
            end else begin
                mcnt--;
            end
        end else begin
            mbusy = 0;
            if (!rst && $urandom_range(99) < stray_pct) begin
                mem_ready = 1'b1;
                mem_rdata = rand_blk();
            end
        end

        #1;
        check("i_ready",   i_ready,   m_live && !m_who && mem_ready);
        check("d_ready",   d_ready,   m_live &&  m_who && mem_ready);
        check("i_rdata",   i_rdata,   (m_live && !m_who && mem_ready) ? mem_rdata : '0);
        check("d_rdata",   d_rdata,   (m_live &&  m_who && mem_ready) ? mem_rdata : '0);
        check("mem_read",  mem_read,  m_live && !m_w);
        check("mem_write", mem_write, m_live && m_w);
        check("mem_addr",  mem_addr,  m_live ? m_addr : '0);
        if (!m_live || m_w) check("mem_wdata", mem_wdata, m_live ? m_wdata : '0);

        // Cache-side scoreboard driven by the ready pulses the DUT actually produced.
        for (int x = 0; x < 2; x++) begin
            rdy = (x == 0) ? i_ready : d_ready;
            rd  = (x == 0) ? i_rdata : d_rdata;
            if (rdy) begin
                tg = (x == 0) ? "i_ready_while_pending" : "d_ready_while_pending";
                check(tg, pend[x], 1'b1);
                if (pend[x]) begin
                    is_w = cur[x].op != 2'd0;
                    a    = cur[x].addr;
                    if (is_w) begin
                        ref_arr[a] = cur[x].wdata;
                    end else begin
                        exp_rd = ref_arr.exists(a) ? ref_arr[a] : dflt(a);
                        check("read_data_end_to_end", rd, exp_rd);
                    end
                    log_q.push_back(x * 2 + int'(is_w));
                    rdy_cnt[x]++;
                    pend[x] = 0;
                end
            end else if (pend[x]) begin
                wait_cnt[x]++;
                if (wait_cnt[x] > WAIT_LIMIT) begin
                    check("request_wait_bound", BW'(wait_cnt[x]), BW'(WAIT_LIMIT));
                    pend[x] = 0;
                end
            end
        end

        if (rst) begin
            m_live = 0;
            m_last = 0;
        end else if (m_live) begin
            if (mem_ready) m_live = 0;
        end else begin
            ia = i_read | i_write;
            da = d_read | d_write;
            if (ia || da) begin
                who     = (ia && da) ? !m_last : da;
                m_live  = 1;
                m_who   = who;
                m_last  = who;
                m_w     = who ? d_write : i_write;
                m_addr  = who ? d_addr : i_addr;
                m_wdata = who ? d_wdata : i_wdata;
            end
        end
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while ((pend[0] || pend[1] || todo_i.size() > 0 || todo_d.size() > 0 || m_live) && n < limit) begin
            step(0);
            n++;
        end
        check("drain_within_bound", n < limit, 1'b1);
    endtask

    task automatic clear_logs();
        log_q.delete();
        rdy_cnt[0] = 0;
        rdy_cnt[1] = 0;
    endtask

    initial begin
        proc_reset = 1'b1;
        {i_read, i_write, d_read, d_write, mem_ready} = '0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
        pend[0] = 0; pend[1] = 0;
        clear_logs();

        // Reset then a single D read with a 3-cycle memory.
        step(1); step(1);
        mem_arr[28'h0000010] = {16{8'hA5}};
        ref_arr[28'h0000010] = {16{8'hA5}};
        lat_cfg = 3;
        todo_d.push_back(mk_req(2'd0, 28'h0000010, '0));
        run_until_idle(50);
        check("single_read_count", BW'(log_q.size()), BW'(1));
        check("single_read_entry", BW'(log_q[0]), BW'(2));
        check("single_read_no_i_ready", BW'(rdy_cnt[0]), BW'(0));
        $display("txn: single D read done, completions=%0d", log_q.size());

        // Tie straight after reset: D goes first.
        step(1); clear_logs();
        lat_cfg = 1;
        todo_i.push_back(mk_req(2'd0, 28'h0000100, '0));
        todo_d.push_back(mk_req(2'd0, 28'h0000200, '0));
        run_until_idle(50);
        check("tie_count", BW'(log_q.size()), BW'(2));
        check("tie_first_is_d", BW'(log_q[0]), BW'(2));
        check("tie_second_is_i", BW'(log_q[1]), BW'(0));
        $display("txn: tie resolved, completions=%0d", log_q.size());

        // Write-back then fetch while the I-cache holds a read.
        step(1); clear_logs();
        lat_cfg = 2;
        todo_d.push_back(mk_req(2'd1, 28'h1234567, {4{32'hDEADBEEF}}));
        todo_d.push_back(mk_req(2'd0, 28'h1234567, '0));
        todo_i.push_back(mk_req(2'd0, 28'h0000020, '0));
        run_until_idle(80);
        check("wb_count", BW'(log_q.size()), BW'(3));
        check("wb_first_d_write", BW'(log_q[0]), BW'(3));
        check("wb_second_i_read", BW'(log_q[1]), BW'(0));
        check("wb_third_d_read", BW'(log_q[2]), BW'(2));
        check("wb_memory_image", mem_arr[28'h1234567], {4{32'hDEADBEEF}});
        $display("txn: write-back then fetch, completions=%0d", log_q.size());

        // Read and write both high: treated as a write.
        step(1); clear_logs();
        lat_cfg = 0;
        todo_d.push_back(mk_req(2'd2, 28'h0000030, {4{32'h0BADF00D}}));
        run_until_idle(30);
        check("both_high_count", BW'(log_q.size()), BW'(1));
        check("both_high_is_write", BW'(log_q[0]), BW'(3));
        $display("txn: read+write both high, completions=%0d", log_q.size());

        // Reset while serving the I-cache, before memory responds.
        step(1); clear_logs();
        lat_cfg = 6;
        todo_i.push_back(mk_req(2'd0, 28'h0000040, '0));
        step(0); step(0); step(0);
        check("abort_serving_before_reset", mem_read, 1'b1);
        step(1);
        step(0); step(0);
        check("abort_no_i_ready", BW'(rdy_cnt[0]), BW'(0));
        check("abort_mem_read_low", mem_read, 1'b0);
        $display("txn: reset mid-transaction, i_ready pulses=%0d", rdy_cnt[0]);

        // Stray mem_ready while idle.
        clear_logs();
        stray_pct = 100;
        step(0); step(0); step(0);
        stray_pct = 0;
        step(0);
        check("stray_no_ready", BW'(rdy_cnt[0] + rdy_cnt[1]), BW'(0));
        check("stray_stays_idle", mem_read | mem_write, 1'b0);
        $display("txn: stray mem_ready ignored, readies=%0d", rdy_cnt[0] + rdy_cnt[1]);

        // Randomized traffic with random latency, drops, stray pulses and resets.
        step(1); clear_logs();
        auto_en = 1; lat_cfg = -1; stray_pct = 5; drop_pct = 3;
        for (int c = 0; c < 3000; c++) step($urandom_range(999) < 3);
        auto_en = 0; stray_pct = 0; drop_pct = 0;
        run_until_idle(300);
        check("random_both_served", (rdy_cnt[0] > 0) && (rdy_cnt[1] > 0), 1'b1);
        $display("txn: random phase, i served=%0d d served=%0d", rdy_cnt[0], rdy_cnt[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
